// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds PC/IR, computes next PC, and fetches over a
// req/ack memory port with wait states, a timeout and a sticky error flag.
module ifu_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWr,
  input  logic        IRWr,
  input  logic [1:0]  NPCOp,
  input  logic [31:0] RD1,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] PC,
  output logic [31:0] IR,
  output logic        busy,
  output logic        err
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [1:0] PC_4   = 2'd0;
  localparam logic [1:0] PC_BEQ = 2'd1;
  localparam logic [1:0] PC_JAL = 2'd2;
  localparam logic [1:0] PC_JR  = 2'd3;

  localparam logic [7:0] WCNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic        pend;
  logic [7:0]  wcnt;
  logic [31:0] npc;

  always_comb begin
    npc = PC + 32'd4;
    case (NPCOp)
      PC_4:    npc = PC + 32'd4;
      PC_BEQ:  npc = PC + {{14{IR[15]}}, IR[15:0], 2'b00};
      PC_JAL:  npc = {PC[31:28], IR[25:0], 2'b00};
      PC_JR:   npc = RD1;
      default: npc = PC + 32'd4;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      PC        <= PC_RESET;
      IR        <= 32'h0;
      imem_req  <= 1'b0;
      imem_addr <= PC_RESET;
      busy      <= 1'b0;
      err       <= 1'b0;
      pend      <= 1'b0;
      wcnt      <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (IRWr) begin
            imem_addr <= PC;
            pend      <= PCWr;
            wcnt      <= 8'd0;
            imem_req  <= 1'b1;
            busy      <= 1'b1;
            state     <= WAIT;
          end else if (PCWr) begin
            PC <= npc;
          end
        end
        WAIT: begin
          // Controller must hold off while busy; stray requests are flagged and dropped.
          if (PCWr || IRWr) err <= 1'b1;
          if (imem_ack || wcnt == WCNT_LAST) begin
            if (imem_ack) begin
              IR <= imem_rdata;
            end else begin
              IR  <= 32'h0;
              err <= 1'b1;
            end
            if (pend) PC <= imem_addr + 32'd4;
            pend     <= 1'b0;
            imem_req <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized self-checking bench for ifu_fetch against a transaction-level model.
module tb_ifu_fetch;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWr, IRWr;
  logic [1:0]  NPCOp;
  logic [31:0] RD1, imem_rdata;
  logic        imem_ack;
  logic        imem_req, busy, err;
  logic [31:0] imem_addr, PC, IR;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_pc, m_ir;
  logic        m_err;

  ifu_fetch #(.PC_RESET(32'h0000_3000), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .PCWr(PCWr), .IRWr(IRWr), .NPCOp(NPCOp), .RD1(RD1),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .imem_req(imem_req),
    .imem_addr(imem_addr), .PC(PC), .IR(IR), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    PCWr = 1'b0; IRWr = 1'b0; NPCOp = 2'd0; imem_ack = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".pc"},  PC,  m_pc);
    check({tag, ".ir"},  IR,  m_ir);
    check({tag, ".err"}, {31'd0, err}, {31'd0, m_err});
    check({tag, ".busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Next-PC as defined by the instruction set semantics.
  function automatic logic [31:0] model_npc(input logic [1:0] op, input logic [31:0] rd1);
    int signed off;
    off = $signed(m_ir[15:0]) * 4;
    case (op)
      2'd0:    return m_pc + 32'd4;
      2'd1:    return m_pc + 32'(off);
      2'd2:    return {m_pc[31:28], 28'(m_ir[25:0]) * 28'd4};
      default: return rd1;
    endcase
  endfunction

  task automatic do_npc(input logic wr, input logic [1:0] op, input logic [31:0] rd1);
    PCWr = wr; IRWr = 1'b0; NPCOp = op; RD1 = rd1;
    imem_ack = 1'($urandom_range(0, 1));
    imem_rdata = $urandom();
    if (wr) m_pc = model_npc(op, rd1);
    step();
    idle_inputs();
    check_state("npc");
    $display("[TB] npc  wr=%0d op=%0d rd1=%08h -> PC=%08h IR=%08h", wr, op, rd1, PC, IR);
  endtask

  // delay = number of WAIT edges without ack before the ack edge
  task automatic do_fetch(input logic pend, input int delay, input logic [31:0] rdata,
                          input logic viol);
    logic [31:0] addr;
    int k, busy_cnt, exp_cnt;
    logic timed_out;
    addr = m_pc;
    timed_out = (delay >= TIMEOUT);
    PCWr = pend; IRWr = 1'b1; NPCOp = 2'd0;
    step();
    idle_inputs();
    k = 0; busy_cnt = 0;
    while (busy === 1'b1 && k < 40) begin
      check("fetch.addr", imem_addr, addr);
      check("fetch.req", {31'd0, imem_req}, 32'd1);
      check("fetch.ir_hold", IR, m_ir);
      busy_cnt++;
      imem_ack   = (k == delay);
      imem_rdata = (k == delay) ? rdata : $urandom();
      if (viol && k == 0) begin
        if ($urandom_range(0, 1) == 1) PCWr = 1'b1; else IRWr = 1'b1;
        m_err = 1'b1;
      end
      step();
      idle_inputs();
      k++;
    end
    if (k >= 40) check("fetch.bound", 32'd40, 32'd0);
    exp_cnt = timed_out ? TIMEOUT : delay + 1;
    check("fetch.busy_cycles", 32'(busy_cnt), 32'(exp_cnt));
    if (timed_out) begin
      m_ir = 32'h0;
      m_err = 1'b1;
    end else begin
      m_ir = rdata;
    end
    if (pend) m_pc = addr + 32'd4;
    check_state("fetch");
    // ack while idle must be ignored
    imem_ack = 1'b1; imem_rdata = $urandom();
    step();
    idle_inputs();
    check_state("late_ack");
    $display("[TB] fetch pend=%0d delay=%0d viol=%0d addr=%08h -> PC=%08h IR=%08h err=%0d",
             pend, delay, viol, addr, PC, IR, err);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    m_pc = 32'h0000_3000; m_ir = 32'h0; m_err = 1'b0;
    check_state(tag);
    check({tag, ".req"}, {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    $display("[TB] reset %s -> PC=%08h IR=%08h", tag, PC, IR);
  endtask

  initial begin
    int delay;
    rst = 1'b0;
    RD1 = 32'h0; imem_rdata = 32'h0;
    idle_inputs();
    @(posedge clk);
    async_reset("reset");

    // directed: minimal fetch and jump targets
    do_fetch(1'b1, 0, 32'h8C01_0004, 1'b0);
    check("t2.ir", IR, 32'h8C01_0004);
    check("t2.pc", PC, 32'h0000_3004);
    do_fetch(1'b1, 3, 32'h1000_FFFE, 1'b0);
    check("t4.pc_pre", PC, 32'h0000_3008);
    do_npc(1'b1, 2'd1, 32'h0);
    check("t4.beq", PC, 32'h0000_3000);
    do_fetch(1'b0, 1, 32'h0C00_0C03, 1'b0);
    do_npc(1'b1, 2'd2, 32'h0);
    check("t4.jal", PC, 32'h0000_300C);
    do_npc(1'b1, 2'd3, 32'h0000_3010);
    check("t4.jr", PC, 32'h0000_3010);

    // directed: timeout
    do_fetch(1'b1, 25, 32'hDEAD_BEEF, 1'b0);
    check("t5.err", {31'd0, err}, 32'd1);
    check("t5.ir", IR, 32'h0);
    check("t5.pc", PC, 32'h0000_3014);

    // directed: reset during WAIT, then ack
    async_reset("reset2");
    PCWr = 1'b1; IRWr = 1'b1;
    step();
    idle_inputs();
    step();
    async_reset("reset_wait");
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    idle_inputs();
    check_state("reset_ack");
    check("reset_ack.req", {31'd0, imem_req}, 32'd0);

    // directed: PC write during WAIT
    do_fetch(1'b0, 2, 32'h0000_0040, 1'b1);
    check("t6.err", {31'd0, err}, 32'd1);
    check("t6.pc", PC, 32'h0000_3000);
    async_reset("reset3");

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_npc(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom());
      end else begin
        delay = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 4) : $urandom_range(0, 20);
        do_fetch(1'($urandom_range(0, 1)), delay, $urandom(),
                 1'($urandom_range(0, 9) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
